// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Latency: one cycle from id_* to EX outputs; forwarding muxes are combinational on EX state.
// Backpressure: stall_in holds EX, flush_in/hazard_stall insert a bubble, flush has priority.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_valid,
    output logic            hazard_stall
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [3:0]      alu_ctrl;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Youngest producer wins; x0 is hardwired zero and never bypassed.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [XLEN-1:0] rf_data,
        input logic            m_we,
        input logic [RA_W-1:0] m_rd,
        input logic [XLEN-1:0] m_res,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_res
    );
        logic [XLEN-1:0] r;
        r = rf_data;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            r = m_res;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            r = w_res;
        end
        return r;
    endfunction

    // Conservative: matches either source field even if the instruction does not read it.
    assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid &&
                          ((id_rs1_addr == ex_q.rd_addr) || (id_rs2_addr == ex_q.rd_addr));

    always_comb begin
        ex_d = ex_q;
        if (flush_in) begin
            ex_d = '0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.mem_read  = id_mem_read & id_valid;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.alu_src   = id_alu_src;
            ex_d.alu_ctrl  = id_alu_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        fwd_rs1 = fwd_sel(ex_q.rs1_addr, ex_q.rs1_data, mem_reg_write, mem_rd_addr, mem_result,
                          wb_reg_write, wb_rd_addr, wb_result);
        fwd_rs2 = fwd_sel(ex_q.rs2_addr, ex_q.rs2_data, mem_reg_write, mem_rd_addr, mem_result,
                          wb_reg_write, wb_rd_addr, wb_result);
    end

    assign alu_a         = fwd_rs1;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_valid      = ex_q.valid;

endmodule
